// File: rtl/prf_multiport_scoreboard_pkg.sv
// Shared PRF/scoreboard types and default sizing for rename, RS and PRF.
// Exports ptag_t, PREG_COUNT, XLEN, NUM_WB_PORTS and related port counts.
package prf_multiport_scoreboard_pkg;

  localparam int PREG_COUNT      = 128;
  localparam int XLEN            = 32;
  localparam int NUM_WB_PORTS    = 3;
  localparam int NUM_RD_PORTS    = 6;
  localparam int NUM_CHK_PORTS   = 6;
  localparam int NUM_ALLOC_PORTS = 3;
  localparam int PTAG_BITS       = $clog2(PREG_COUNT);

  typedef logic [PTAG_BITS-1:0] ptag_t;

endpackage

// File: rtl/prf_multiport_scoreboard_if.sv
// Bundle of PRF read/write/query/alloc/restore/wakeup signals.
// master = client side (RS, FUs, rename); slave = the register file.
interface prf_multiport_scoreboard_if
  import prf_multiport_scoreboard_pkg::*;
#(
  parameter int NUM_PREGS = PREG_COUNT,
  parameter int DATA_W    = XLEN,
  parameter int NUM_WR    = NUM_WB_PORTS,
  parameter int NUM_RD    = NUM_RD_PORTS,
  parameter int NUM_CHK   = NUM_CHK_PORTS,
  parameter int NUM_ALLOC = NUM_ALLOC_PORTS
);
  localparam int PTAG_W = $clog2(NUM_PREGS);

  logic [NUM_RD*PTAG_W-1:0]    rd_tag;
  logic [NUM_RD*DATA_W-1:0]    rd_data;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*PTAG_W-1:0]    wr_tag;
  logic [NUM_WR*DATA_W-1:0]    wr_data;
  logic [NUM_CHK*PTAG_W-1:0]   chk_tag;
  logic [NUM_CHK-1:0]          chk_rdy;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*PTAG_W-1:0] alloc_tag;
  logic                        restore_valid;
  logic [NUM_PREGS-1:0]        restore_mask;
  logic [NUM_WR-1:0]           wake_valid;
  logic [NUM_WR*PTAG_W-1:0]    wake_tag;

  modport master (
    output rd_tag, wr_en, wr_tag, wr_data,
    output chk_tag, alloc_en, alloc_tag,
    output restore_valid, restore_mask,
    input  rd_data, chk_rdy, wake_valid, wake_tag
  );

  modport slave (
    input  rd_tag, wr_en, wr_tag, wr_data,
    input  chk_tag, alloc_en, alloc_tag,
    input  restore_valid, restore_mask,
    output rd_data, chk_rdy, wake_valid, wake_tag
  );

endinterface

// File: rtl/prf_multiport_scoreboard_ready_table.sv
// prf_ready_table: per-preg ready bits, chk ports and wakeup registers.
// Ports: clk, reset (sync, active-low), wr/alloc/restore in, chk_rdy/wake out.
// PRF_BYPASS_EN: chk_rdy also reflects same-cycle writebacks.
module prf_ready_table
  import prf_multiport_scoreboard_pkg::*;
#(
  parameter int NUM_PREGS = PREG_COUNT,
  parameter int NUM_WR    = NUM_WB_PORTS,
  parameter int NUM_CHK   = NUM_CHK_PORTS,
  parameter int NUM_ALLOC = NUM_ALLOC_PORTS,
  localparam int PTAG_W   = $clog2(NUM_PREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*PTAG_W-1:0]    wr_tag,
  input  logic [NUM_CHK*PTAG_W-1:0]   chk_tag,
  output logic [NUM_CHK-1:0]          chk_rdy,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*PTAG_W-1:0] alloc_tag,
  input  logic                        restore_valid,
  input  logic [NUM_PREGS-1:0]        restore_mask,
  output logic [NUM_WR-1:0]           wake_valid,
  output logic [NUM_WR*PTAG_W-1:0]    wake_tag
);

  logic [NUM_PREGS-1:0] rdy;
  logic [NUM_PREGS-1:0] rdy_nxt;
  logic [NUM_WR-1:0]    wr_live;

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wr_live[i] = wr_en[i] &&
        (wr_tag[i*PTAG_W +: PTAG_W] != '0);
    end
  end

  // Writes and restore set first; alloc then
  // clears, so alloc beats a same-cycle write.
  always_comb begin
    rdy_nxt = rdy;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_live[i])
        rdy_nxt[wr_tag[i*PTAG_W +: PTAG_W]] = 1'b1;
    end
    if (restore_valid) begin
      rdy_nxt = rdy_nxt | restore_mask;
    end else begin
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_en[j])
          rdy_nxt[alloc_tag[j*PTAG_W +: PTAG_W]] = 1'b0;
      end
    end
    rdy_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy        <= '1;
      wake_valid <= '0;
      wake_tag   <= '0;
    end else begin
      rdy        <= rdy_nxt;
      wake_valid <= wr_live;
      wake_tag   <= wr_tag;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHK; c++) begin
      chk_rdy[c] = rdy[chk_tag[c*PTAG_W +: PTAG_W]];
`ifdef PRF_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_live[i] &&
            wr_tag[i*PTAG_W +: PTAG_W] ==
            chk_tag[c*PTAG_W +: PTAG_W])
          chk_rdy[c] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/prf_multiport_scoreboard.sv
// Physical register file with integrated ready scoreboard and wakeup.
// Ports: clk, reset (sync, active-low), bus (slave modport of the _if).
// PRF_BYPASS_EN: rd_data/chk_rdy forward same-cycle writebacks.
module prf_multiport_scoreboard
  import prf_multiport_scoreboard_pkg::*;
#(
  parameter int NUM_PREGS = PREG_COUNT,
  parameter int DATA_W    = XLEN,
  parameter int NUM_WR    = NUM_WB_PORTS,
  parameter int NUM_RD    = NUM_RD_PORTS,
  parameter int NUM_CHK   = NUM_CHK_PORTS,
  parameter int NUM_ALLOC = NUM_ALLOC_PORTS
) (
  input logic                     clk,
  input logic                     reset,
  prf_multiport_scoreboard_if.slave bus
);

  localparam int PTAG_W = $clog2(NUM_PREGS);

  logic [DATA_W-1:0] mem [NUM_PREGS];

  // Later ports overwrite earlier ones in the loop,
  // so the highest index wins on a tag clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PREGS; p++)
        mem[p] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] &&
            bus.wr_tag[i*PTAG_W +: PTAG_W] != '0)
          mem[bus.wr_tag[i*PTAG_W +: PTAG_W]] <=
            bus.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (bus.rd_tag[r*PTAG_W +: PTAG_W] != '0) begin
        bus.rd_data[r*DATA_W +: DATA_W] =
          mem[bus.rd_tag[r*PTAG_W +: PTAG_W]];
`ifdef PRF_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++) begin
          if (bus.wr_en[i] &&
              bus.wr_tag[i*PTAG_W +: PTAG_W] ==
              bus.rd_tag[r*PTAG_W +: PTAG_W])
            bus.rd_data[r*DATA_W +: DATA_W] =
              bus.wr_data[i*DATA_W +: DATA_W];
        end
`endif
      end
    end
  end

  prf_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_WR    (NUM_WR),
    .NUM_CHK   (NUM_CHK),
    .NUM_ALLOC (NUM_ALLOC)
  ) u_rdy (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (bus.wr_en),
    .wr_tag        (bus.wr_tag),
    .chk_tag       (bus.chk_tag),
    .chk_rdy       (bus.chk_rdy),
    .alloc_en      (bus.alloc_en),
    .alloc_tag     (bus.alloc_tag),
    .restore_valid (bus.restore_valid),
    .restore_mask  (bus.restore_mask),
    .wake_valid    (bus.wake_valid),
    .wake_tag      (bus.wake_tag)
  );

endmodule

// File: tb/tb_prf_multiport_scoreboard.sv
// Self-checking bench for prf_multiport_scoreboard (default sizes).
// Expected read data is queued at write time and popped at read time.
module tb_prf_multiport_scoreboard;

  localparam int PW = 7;
  localparam int DW = 32;
`ifdef PRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prf_multiport_scoreboard_if bus();

  prf_multiport_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          port;
    int          tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic idle();
    bus.rd_tag        = '0;
    bus.wr_en         = '0;
    bus.wr_tag        = '0;
    bus.wr_data       = '0;
    bus.chk_tag       = '0;
    bus.alloc_en      = '0;
    bus.alloc_tag     = '0;
    bus.restore_valid = 1'b0;
    bus.restore_mask  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(int p, int t);
    bus.rd_tag[p*PW +: PW] = PW'(t);
  endtask

  task automatic set_chk(int p, int t);
    bus.chk_tag[p*PW +: PW] = PW'(t);
  endtask

  task automatic set_wr(int p, int t, logic [31:0] d);
    bus.wr_en[p]            = 1'b1;
    bus.wr_tag[p*PW +: PW]  = PW'(t);
    bus.wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_alloc(int p, int t);
    bus.alloc_en[p]           = 1'b1;
    bus.alloc_tag[p*PW +: PW] = PW'(t);
  endtask

  function automatic logic [31:0] rdv(int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  function automatic int wtag(int p);
    return int'(bus.wake_tag[p*PW +: PW]);
  endfunction

  task automatic drain(string nm);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rdv(e.port) !== e.data) begin
        bad++;
        $display("FAIL %s tag=%0d got=%h exp=%h",
                 nm, e.tag, rdv(e.port), e.data);
      end
    end
  endtask

  task automatic test_reset();
    int tags[6] = '{0, 5, 9, 12, 20, 127};
    reset = 1'b0;
    idle();
    set_alloc(0, 3);
    cyc();
    reset = 1'b1;
    idle();
    for (int c = 0; c < 6; c++) begin
      set_chk(c, tags[c]);
      set_rd(c, tags[c]);
    end
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      total++;
      if (bus.chk_rdy[c] !== 1'b1) begin
        bad++;
        $display("FAIL reset_rdy tag=%0d got=%b exp=1",
                 tags[c], bus.chk_rdy[c]);
      end
      total++;
      if (rdv(c) !== 32'h0) begin
        bad++;
        $display("FAIL reset_data tag=%0d got=%h exp=0",
                 tags[c], rdv(c));
      end
    end
    total++;
    if (bus.wake_valid !== 3'b000) begin
      bad++;
      $display("FAIL reset_wake got=%b exp=000",
               bus.wake_valid);
    end
  endtask

  task automatic test_write_wake();
    logic [31:0] e;
    cyc();
    idle();
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    sb.push_back('{0, 5, 32'hDEADBEEF});
    @(negedge clk);
    e = BYP ? 32'hDEADBEEF : 32'h0;
    total++;
    if (rdv(0) !== e) begin
      bad++;
      $display("FAIL wr_same_cycle got=%h exp=%h", rdv(0), e);
    end
    cyc();
    idle();
    set_rd(sb[0].port, sb[0].tag);
    @(negedge clk);
    drain("wr_read");
    total++;
    if (bus.wake_valid !== 3'b001 || wtag(0) != 5) begin
      bad++;
      $display("FAIL wake got=%b/%0d exp=001/5",
               bus.wake_valid, wtag(0));
    end
    cyc();
    idle();
    @(negedge clk);
    total++;
    if (bus.wake_valid !== 3'b000) begin
      bad++;
      $display("FAIL wake_clear got=%b exp=000",
               bus.wake_valid);
    end
  endtask

  task automatic test_alloc();
    cyc();
    idle();
    set_alloc(0, 9);
    set_chk(0, 9);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL alloc_same got=%b exp=1", bus.chk_rdy[0]);
    end
    cyc();
    idle();
    set_chk(0, 9);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL alloc_next got=%b exp=0", bus.chk_rdy[0]);
    end
    cyc();
    idle();
    set_wr(1, 9, 32'h99);
    set_chk(0, 9);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[0] !== BYP) begin
      bad++;
      $display("FAIL wr_rdy_same got=%b exp=%b",
               bus.chk_rdy[0], BYP);
    end
    cyc();
    idle();
    set_chk(0, 9);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[0] !== 1'b1 || bus.wake_valid !== 3'b010) begin
      bad++;
      $display("FAIL wr_rdy_next got=%b/%b exp=1/010",
               bus.chk_rdy[0], bus.wake_valid);
    end
  endtask

  task automatic test_alloc_write();
    cyc();
    idle();
    set_alloc(1, 12);
    set_wr(1, 12, 32'h1234);
    set_wr(0, 7, 32'hAAAA);
    set_wr(2, 7, 32'hBBBB);
    sb.push_back('{0, 12, 32'h1234});
    sb.push_back('{1, 7, 32'hBBBB});
    cyc();
    idle();
    set_chk(0, 12);
    foreach (sb[k]) set_rd(sb[k].port, sb[k].tag);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL alloc_beats_wr got=%b exp=0",
               bus.chk_rdy[0]);
    end
    total++;
    if (bus.wake_valid !== 3'b111) begin
      bad++;
      $display("FAIL wake_multi got=%b exp=111",
               bus.wake_valid);
    end
    drain("multi_wr");
  endtask

  task automatic test_restore();
    cyc();
    idle();
    set_alloc(0, 20);
    set_alloc(1, 21);
    cyc();
    idle();
    set_chk(0, 20);
    set_chk(1, 21);
    set_chk(2, 22);
    bus.restore_valid    = 1'b1;
    bus.restore_mask[20] = 1'b1;
    bus.restore_mask[21] = 1'b1;
    set_alloc(2, 22);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[2:0] !== 3'b100) begin
      bad++;
      $display("FAIL restore_same got=%b exp=100",
               bus.chk_rdy[2:0]);
    end
    cyc();
    idle();
    set_chk(0, 20);
    set_chk(1, 21);
    set_chk(2, 22);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[2:0] !== 3'b111) begin
      bad++;
      $display("FAIL restore_next got=%b exp=111",
               bus.chk_rdy[2:0]);
    end
  endtask

  task automatic test_tag0();
    cyc();
    idle();
    set_wr(0, 0, 32'h1);
    set_rd(0, 0);
    set_chk(0, 0);
    @(negedge clk);
    total++;
    if (rdv(0) !== 32'h0 || bus.chk_rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL tag0_same got=%h/%b exp=0/1",
               rdv(0), bus.chk_rdy[0]);
    end
    cyc();
    idle();
    set_rd(0, 0);
    @(negedge clk);
    total++;
    if (rdv(0) !== 32'h0 || bus.wake_valid !== 3'b000) begin
      bad++;
      $display("FAIL tag0_next got=%h/%b exp=0/000",
               rdv(0), bus.wake_valid);
    end
  endtask

  task automatic test_reset_mid_alloc();
    cyc();
    idle();
    set_alloc(0, 30);
    set_alloc(1, 31);
    set_alloc(2, 32);
    set_wr(0, 40, 32'h55);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    idle();
    set_chk(0, 30);
    set_chk(1, 31);
    set_chk(2, 32);
    set_chk(3, 9);
    set_rd(0, 5);
    set_rd(1, 40);
    @(negedge clk);
    total++;
    if (bus.chk_rdy[3:0] !== 4'b1111) begin
      bad++;
      $display("FAIL rst_alloc got=%b exp=1111",
               bus.chk_rdy[3:0]);
    end
    total++;
    if (rdv(0) !== 32'h0 || rdv(1) !== 32'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h exp=0/0",
               rdv(0), rdv(1));
    end
    total++;
    if (bus.wake_valid !== 3'b000) begin
      bad++;
      $display("FAIL rst_wake got=%b exp=000",
               bus.wake_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mdl [16];
    int          tg  [3];
    logic [2:0]  en;
    for (int it = 0; it < 12; it++) begin
      cyc();
      idle();
      en = '0;
      for (int p = 0; p < 3; p++) begin
        if (p == 0 || $urandom_range(0, 1) == 1) begin
          tg[p] = $urandom_range(1, 15);
          en[p] = 1'b1;
          mdl[tg[p]] = $urandom;
          set_wr(p, tg[p], mdl[tg[p]]);
        end
      end
      for (int p = 0; p < 3; p++)
        if (en[p]) sb.push_back('{p, tg[p], mdl[tg[p]]});
      cyc();
      idle();
      foreach (sb[k]) set_rd(sb[k].port, sb[k].tag);
      @(negedge clk);
      total++;
      if (bus.wake_valid !== en) begin
        bad++;
        $display("FAIL b2b_wake it=%0d got=%b exp=%b",
                 it, bus.wake_valid, en);
      end
      drain("b2b_read");
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_write_wake();
    test_alloc();
    test_alloc_write();
    test_restore();
    test_tag0();
    test_reset_mid_alloc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
